sls_access_sequencer: RTL and testbench
=======================================

Name: sls_access_sequencer

Overview:
- Sequential successor to the combinational single load/store RAM-setting decoder.
- Decodes addressing-mode-2/3 instructions and drives the RAM handshake: MOC out, MFC back.
- Adds a doubleword split into two word accesses, alignment checking, load sign-extension, an MFC timeout and a done/error report.
- Sits between the control unit (start/done) and the data RAM.

Parameters:
- DATA_W, 32: word width; must be >= 32. Byte and halfword stay 8/16 bits.
- ADDR_W, 32: address width; must be >= 3.
- MFC_TIMEOUT, 15: maximum WAIT cycles without MFC before error; must be >= 1.

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- IR  in  32  instruction word.
- ea  in  ADDR_W  effective address, already computed.
- st_data  in  DATA_W  Rd store data.
- st_data_hi  in  DATA_W  Rd+1 store data (STRD).
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rw  out  1  1 = read, 0 = write.
- mem_size  out  2  00 byte, 01 halfword, 10 word (a doubleword issues 10 twice).
- mem_sign  out  1  signed load.
- mem_moc  out  1  memory operation command.
- mem_mfc  in  1  memory function complete.
- mem_rdata  in  DATA_W  RAM read data, right-justified.
- ld_data  out  DATA_W  load result, extended.
- ld_data_hi  out  DATA_W  second word of LDRD.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with done.

Behaviour:
- Reset (async, Reset_n = 0): state IDLE; all outputs 0; timeout counter 0. Reset mid-operation aborts at once and issues no done.
- Decode, on start in IDLE, with L = IR[20]:
  - Mode 2, IR[27:26] = 01: byte if IR[22] = 1, else word. Unsigned. Load if L.
  - Mode 3, IR[27:25] = 000, IR[7] = 1, IR[4] = 1, SH = IR[6:5]:
    - L = 1: 01 LDRH (half, unsigned); 10 LDRSB (byte, signed); 11 LDRSH (half, signed).
    - L = 0: 01 STRH; 10 LDRD (read); 11 STRD (write). LDRD/STRD are doubleword.
  - Anything else, including SH = 00, is illegal.
- Alignment: halfword needs ea[0] = 0; word needs ea[1:0] = 0; doubleword needs ea[2:0] = 0.
- States: IDLE, WAIT1, GAP, WAIT2, DONE, ERR.
  - IDLE, start, legal and aligned: register addr/size/rw/sign/wdata, set mem_moc = 1 → WAIT1.
  - IDLE, start, illegal or misaligned: → ERR. No MOC is asserted.
  - WAIT1: MOC and all mem_* held stable.
    - mem_mfc = 1: capture load data, drop MOC. Doubleword → GAP; otherwise → DONE.
    - Counter reaches MFC_TIMEOUT without MFC → ERR.
  - GAP: one cycle with MOC = 0. mem_addr = ea + 4; wdata = st_data_hi. → WAIT2 with MOC = 1.
  - WAIT2: same as WAIT1. Load data goes to ld_data_hi. Then → DONE.
  - DONE: done = 1 for one cycle → IDLE.
  - ERR: done = 1 and err = 1 for one cycle → IDLE. ld_data outputs are not updated on error.
- Timeout counter: clears on entry to each WAIT state; width clog2(MFC_TIMEOUT + 1).
- Loads:
  - Byte: ld_data = mem_rdata[7:0], zero- or sign-extended to DATA_W.
  - Halfword: mem_rdata[15:0], zero- or sign-extended likewise.
  - Word: passed through unchanged.
  - ld_data/ld_data_hi hold until the next successful load capture.
- Stores: mem_wdata = st_data (unmasked; RAM uses mem_size). Stores never change ld_data.
- Latency with MFC in the first WAIT cycle:
  - Single access: start at cycle 0, MOC cycles 1, done cycle 2.
  - Doubleword: MOC 1, gap 2, MOC 3, done 4.
- start while busy is ignored, not queued. mem_mfc outside WAIT states is ignored.
- mem_moc goes low on the edge after MFC is seen.

Decomposition:
- Shared package sls_pkg:
  - Size codes SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD.
  - State encoding.
  - IR field position constants (L_BIT = 20, B_BIT = 22, SH = 6:5).
- Natural sub-module sls_decode: combinational IR + ea → legal, misaligned, size, rw, sign, dword.
- The sequencer FSM, counter and extension logic stay in the top module.

Test Plan:
- LDRSB: IR = 0xE1D000D0, ea = 0x1003, MFC in the first wait cycle, rdata = 0x00000080. Required: mem_size = 00, mem_sign = 1, mem_rw = 1, ld_data = 0xFFFFFF80, done at cycle 2, err = 0.
- STRD: IR = 0xE1C000F0, ea = 0x2000, st_data = 0xA, st_data_hi = 0xB, MFC after 2 wait cycles each. Required: two MOC pulses, addr 0x2000 then 0x2004, wdata 0xA then 0xB, mem_rw = 0, one gap cycle with MOC = 0, then a single done.
- Misaligned LDRH: IR = 0xE1D000B0, ea = 0x3001. Required: no MOC; done = 1 and err = 1 on cycle 1; ld_data unchanged.
- Timeout: LDR word, IR = 0xE5900000, MFC never asserted. Required: MOC high for exactly MFC_TIMEOUT (15) cycles, then err = 1 and done = 1 for one cycle.
- Reset mid-operation: Reset_n low during WAIT2 of an LDRD. Required: all outputs 0 immediately, no done; the next start (LDRB, rdata = 0x000000FF) gives ld_data = 0x000000FF.
- start pulsed while busy: ignored. A single done is produced for the original request.

Source files
------------

// File: rtl/sls_pkg.sv
// Shared definitions for the single load/store access sequencer:
// size codes, FSM state encoding and instruction field positions.
package sls_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  localparam int L_BIT = 20;
  localparam int B_BIT = 22;
  localparam int SH_HI = 6;
  localparam int SH_LO = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT1,
    S_GAP,
    S_WAIT2,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/sls_decode.sv
// Combinational decode of addressing-mode-2/3 load/store instructions
// into access size, direction, signedness and an alignment verdict.
module sls_decode
  import sls_pkg::*;
(
  input  logic [31:0] ir,
  input  logic [2:0]  ea_lo,
  output logic        legal,
  output logic        misaligned,
  output logic [1:0]  size,
  output logic        rw,
  output logic        sign,
  output logic        dword
);

  logic [1:0] sh;
  logic       unused_ir;

  assign unused_ir = ^{ir[31:28], ir[24:23], ir[21], ir[19:8], ir[3:0]};

  always_comb begin
    sh         = ir[SH_HI:SH_LO];
    legal      = 1'b0;
    rw         = 1'b0;
    sign       = 1'b0;
    dword      = 1'b0;
    size       = SZ_WORD;
    misaligned = 1'b0;

    if (ir[27:26] == 2'b01) begin
      legal = 1'b1;
      rw    = ir[L_BIT];
      size  = ir[B_BIT] ? SZ_BYTE : SZ_WORD;
    end else if (ir[27:25] == 3'b000 && ir[7] && ir[4] && sh != 2'b00) begin
      legal = 1'b1;
      // With L clear, SH=10/11 repurpose the load/store encoding as LDRD/STRD.
      unique case ({ir[L_BIT], sh})
        3'b101:  begin rw = 1'b1; size = SZ_HALF; end
        3'b110:  begin rw = 1'b1; size = SZ_BYTE; sign = 1'b1; end
        3'b111:  begin rw = 1'b1; size = SZ_HALF; sign = 1'b1; end
        3'b001:  begin rw = 1'b0; size = SZ_HALF; end
        3'b010:  begin rw = 1'b1; size = SZ_DWORD; dword = 1'b1; end
        3'b011:  begin rw = 1'b0; size = SZ_DWORD; dword = 1'b1; end
        default: legal = 1'b0;
      endcase
    end

    case (size)
      SZ_HALF:  misaligned = ea_lo[0];
      SZ_WORD:  misaligned = |ea_lo[1:0];
      SZ_DWORD: misaligned = |ea_lo;
      default:  misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/sls_access_sequencer.sv
// Load/store sequencer: drives the MOC/MFC RAM handshake, splits doublewords
// into two word accesses, extends loads and reports done/err to the control unit.
module sls_access_sequencer
  import sls_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MFC_TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [31:0]       IR,
  input  logic [ADDR_W-1:0] ea,
  input  logic [DATA_W-1:0] st_data,
  input  logic [DATA_W-1:0] st_data_hi,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rw,
  output logic [1:0]        mem_size,
  output logic              mem_sign,
  output logic              mem_moc,
  input  logic              mem_mfc,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] ld_data_hi,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(MFC_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MFC_TIMEOUT - 1);

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              dword_q;
  logic [DATA_W-1:0] wdata_hi_q;
  logic [DATA_W-1:0] lo_buf;
  logic [DATA_W-1:0] ext_data;

  logic       dec_legal, dec_misaligned, dec_rw, dec_sign, dec_dword;
  logic [1:0] dec_size;

  sls_decode u_decode (
    .ir         (IR),
    .ea_lo      (ea[2:0]),
    .legal      (dec_legal),
    .misaligned (dec_misaligned),
    .size       (dec_size),
    .rw         (dec_rw),
    .sign       (dec_sign),
    .dword      (dec_dword)
  );

  always_comb begin
    ext_data = mem_rdata;
    case (mem_size)
      SZ_BYTE: ext_data = mem_sign ? {{(DATA_W-8){mem_rdata[7]}}, mem_rdata[7:0]}
                                   : {{(DATA_W-8){1'b0}}, mem_rdata[7:0]};
      SZ_HALF: ext_data = mem_sign ? {{(DATA_W-16){mem_rdata[15]}}, mem_rdata[15:0]}
                                   : {{(DATA_W-16){1'b0}}, mem_rdata[15:0]};
      default: ext_data = mem_rdata;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      dword_q    <= 1'b0;
      wdata_hi_q <= '0;
      lo_buf     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_rw     <= 1'b0;
      mem_size   <= 2'b00;
      mem_sign   <= 1'b0;
      mem_moc    <= 1'b0;
      ld_data    <= '0;
      ld_data_hi <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (dec_legal && !dec_misaligned) begin
              mem_addr   <= ea;
              mem_wdata  <= st_data;
              wdata_hi_q <= st_data_hi;
              mem_rw     <= dec_rw;
              mem_size   <= dec_dword ? SZ_WORD : dec_size;
              mem_sign   <= dec_sign;
              dword_q    <= dec_dword;
              mem_moc    <= 1'b1;
              wait_cnt   <= '0;
              state      <= S_WAIT1;
            end else begin
              done  <= 1'b1;
              err   <= 1'b1;
              state <= S_ERR;
            end
          end
        end
        // First word of a doubleword is parked in lo_buf so an error on the
        // second access leaves ld_data untouched.
        S_WAIT1: begin
          if (mem_mfc) begin
            mem_moc <= 1'b0;
            if (dword_q) begin
              lo_buf    <= mem_rdata;
              mem_addr  <= mem_addr + ADDR_W'(4);
              mem_wdata <= wdata_hi_q;
              state     <= S_GAP;
            end else begin
              if (mem_rw) ld_data <= ext_data;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end else if (wait_cnt == CNT_LAST) begin
            mem_moc <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
            state   <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_GAP: begin
          mem_moc  <= 1'b1;
          wait_cnt <= '0;
          state    <= S_WAIT2;
        end
        S_WAIT2: begin
          if (mem_mfc) begin
            mem_moc <= 1'b0;
            if (mem_rw) begin
              ld_data    <= lo_buf;
              ld_data_hi <= mem_rdata;
            end
            done  <= 1'b1;
            state <= S_DONE;
          end else if (wait_cnt == CNT_LAST) begin
            mem_moc <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
            state   <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_DONE, S_ERR: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          mem_moc <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sls_access_sequencer.sv
// Randomized bench for sls_access_sequencer: a byte-count/arithmetic reference
// model predicts each transaction's handshake, timing and load results.
module tb_sls_access_sequencer;

  localparam int TMO = 15;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] IR = '0;
  logic [31:0] ea = '0;
  logic [31:0] st_data = '0;
  logic [31:0] st_data_hi = '0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rw;
  logic [1:0]  mem_size;
  logic        mem_sign;
  logic        mem_moc;
  logic        mem_mfc = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] ld_data;
  logic [31:0] ld_data_hi;
  logic        busy;
  logic        done;
  logic        err;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] model_ld = '0;
  logic [31:0] model_hi = '0;

  always #5 Clk = ~Clk;

  sls_access_sequencer #(.DATA_W(32), .ADDR_W(32), .MFC_TIMEOUT(TMO)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .start      (start),
    .IR         (IR),
    .ea         (ea),
    .st_data    (st_data),
    .st_data_hi (st_data_hi),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rw     (mem_rw),
    .mem_size   (mem_size),
    .mem_sign   (mem_sign),
    .mem_moc    (mem_moc),
    .mem_mfc    (mem_mfc),
    .mem_rdata  (mem_rdata),
    .ld_data    (ld_data),
    .ld_data_hi (ld_data_hi),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    start = 1'b0;
  endtask

  // Reference decode: number of bytes moved, direction and signedness.
  function automatic void refDecode(input logic [31:0] ir, input logic [31:0] a,
                                    output bit ok, output int nbytes,
                                    output bit is_rd, output bit sgn);
    ok = 0; nbytes = 4; is_rd = ir[20]; sgn = 0;
    if (ir[27:26] == 2'b01) begin
      ok = 1;
      nbytes = ir[22] ? 1 : 4;
    end else if (ir[27:25] == 3'b000 && ir[7] && ir[4]) begin
      case ({ir[20], ir[6:5]})
        3'b101: begin ok = 1; nbytes = 2; end
        3'b110: begin ok = 1; nbytes = 1; sgn = 1; end
        3'b111: begin ok = 1; nbytes = 2; sgn = 1; end
        3'b001: begin ok = 1; nbytes = 2; end
        3'b010: begin ok = 1; nbytes = 8; is_rd = 1; end
        3'b011: begin ok = 1; nbytes = 8; end
        default: ok = 0;
      endcase
    end
    if (ok && (a % nbytes) != 0) ok = 0;
  endfunction

  function automatic logic [31:0] refExtend(input logic [31:0] r, input int nbytes, input bit sgn);
    logic [31:0] v;
    if (nbytes == 1) begin
      v = r & 32'hFF;
      if (sgn && v >= 32'h80) v = v - 32'h100;
    end else if (nbytes == 2) begin
      v = r & 32'hFFFF;
      if (sgn && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = r;
    end
    return v;
  endfunction

  function automatic int pickDelay();
    if ($urandom_range(0, 9) == 0) return 40;
    return int'($urandom_range(0, 4));
  endfunction

  // One full transaction; dN >= TMO means that access never sees MFC.
  task automatic applyStimulus(input logic [31:0] ir, input logic [31:0] ea_v,
                               input logic [31:0] sd, input logic [31:0] sdh,
                               input int d0, input int d1,
                               input logic [31:0] r0, input logic [31:0] r1,
                               input bit poke);
    bit          ok, is_rd, sgn, tmo;
    int          nbytes, n_acc, dly, w;
    logic [31:0] rv, exp_addr, exp_wdata;
    logic [1:0]  exp_size;
    refDecode(ir, ea_v, ok, nbytes, is_rd, sgn);
    n_acc = (nbytes == 8) ? 2 : 1;
    exp_size = (nbytes == 1) ? 2'b00 : (nbytes == 2) ? 2'b01 : 2'b10;
    tmo = 0;
    IR = ir; ea = ea_v; st_data = sd; st_data_hi = sdh; start = 1'b1;
    @(negedge Clk);
    start = poke;
    if (poke) IR = $urandom;
    checkOutput("busy", {63'd0, busy}, 64'd1);
    if (!ok) begin
      checkOutput("rej_done", {63'd0, done}, 64'd1);
      checkOutput("rej_err", {63'd0, err}, 64'd1);
      checkOutput("rej_moc", {63'd0, mem_moc}, 64'd0);
    end else begin
      for (int a = 0; a < n_acc; a++) begin
        exp_addr  = ea_v + 32'(4 * a);
        exp_wdata = (a == 1) ? sdh : sd;
        if (a == 1) begin
          checkOutput("gap_moc", {63'd0, mem_moc}, 64'd0);
          checkOutput("gap_addr", {32'd0, mem_addr}, {32'd0, exp_addr});
          checkOutput("gap_done", {63'd0, done}, 64'd0);
          mem_mfc = 1'($urandom_range(0, 1));
          mem_rdata = $urandom;
          tick();
          mem_mfc = 1'b0;
        end
        dly = (a == 1) ? d1 : d0;
        rv  = (a == 1) ? r1 : r0;
        w = 0;
        while (1) begin
          checkOutput("moc", {63'd0, mem_moc}, 64'd1);
          checkOutput("addr", {32'd0, mem_addr}, {32'd0, exp_addr});
          checkOutput("wdata", {32'd0, mem_wdata}, {32'd0, exp_wdata});
          checkOutput("rw", {63'd0, mem_rw}, {63'd0, is_rd});
          checkOutput("size", {62'd0, mem_size}, {62'd0, exp_size});
          checkOutput("sign", {63'd0, mem_sign}, {63'd0, sgn});
          checkOutput("wait_done", {63'd0, done}, 64'd0);
          if (w == dly) begin
            mem_mfc = 1'b1;
            mem_rdata = rv;
            tick();
            mem_mfc = 1'b0;
            mem_rdata = $urandom;
            break;
          end
          if (w == TMO - 1) begin
            tick();
            tmo = 1;
            break;
          end
          w++;
          tick();
        end
        if (tmo) break;
      end
      checkOutput("end_done", {63'd0, done}, 64'd1);
      checkOutput("end_err", {63'd0, err}, {63'd0, tmo});
      checkOutput("end_moc", {63'd0, mem_moc}, 64'd0);
      if (!tmo && is_rd) begin
        if (n_acc == 2) begin
          model_ld = r0;
          model_hi = r1;
        end else begin
          model_ld = refExtend(r0, nbytes, sgn);
        end
      end
    end
    checkOutput("ld_data", {32'd0, ld_data}, {32'd0, model_ld});
    checkOutput("ld_data_hi", {32'd0, ld_data_hi}, {32'd0, model_hi});
    mem_mfc = 1'($urandom_range(0, 1));
    tick();
    mem_mfc = 1'b0;
    checkOutput("idle_done", {63'd0, done}, 64'd0);
    checkOutput("idle_busy", {63'd0, busy}, 64'd0);
    checkOutput("idle_moc", {63'd0, mem_moc}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rir, rea;

    repeat (2) @(negedge Clk);
    checkOutput("rst_moc", {63'd0, mem_moc}, 64'd0);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    checkOutput("rst_ld", {32'd0, ld_data}, 64'd0);
    checkOutput("rst_addr", {32'd0, mem_addr}, 64'd0);
    Reset_n = 1'b1;
    tick();

    $display("[TB] LDRSB byte sign-extension");
    applyStimulus(32'hE1D000D0, 32'h1003, 32'h0, 32'h0, 0, 0, 32'h00000080, 32'h0, 1'b0);
    checkOutput("ldrsb_value", {32'd0, ld_data}, 64'hFFFFFF80);

    $display("[TB] STRD split with two-cycle MFC latency");
    applyStimulus(32'hE1C000F0, 32'h2000, 32'hA, 32'hB, 2, 2, 32'h0, 32'h0, 1'b0);

    $display("[TB] misaligned LDRH");
    applyStimulus(32'hE1D000B0, 32'h3001, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 1'b0);

    $display("[TB] LDR word timeout");
    applyStimulus(32'hE5900000, 32'h0100, 32'h0, 32'h0, 99, 0, 32'h0, 32'h0, 1'b0);

    $display("[TB] start pulsed while busy");
    applyStimulus(32'hE5900000, 32'h0200, 32'h0, 32'h0, 3, 0, 32'h12345678, 32'h0, 1'b1);
    checkOutput("busy_start_ld", {32'd0, ld_data}, 64'h12345678);

    $display("[TB] reset during WAIT2 of LDRD");
    IR = 32'hE1C000D0; ea = 32'h4000; start = 1'b1;
    tick();
    mem_mfc = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_mfc = 1'b0;
    tick();
    checkOutput("pre_rst_moc", {63'd0, mem_moc}, 64'd1);
    #1 Reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_moc", {63'd0, mem_moc}, 64'd0);
    checkOutput("mid_rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("mid_rst_done", {63'd0, done}, 64'd0);
    checkOutput("mid_rst_ld", {32'd0, ld_data}, 64'd0);
    checkOutput("mid_rst_addr", {32'd0, mem_addr}, 64'd0);
    model_ld = '0;
    model_hi = '0;
    repeat (2) begin
      tick();
      checkOutput("rst_no_done", {63'd0, done}, 64'd0);
    end
    Reset_n = 1'b1;
    tick();
    applyStimulus(32'hE5D00000, 32'h5001, 32'h0, 32'h0, 0, 0, 32'h000000FF, 32'h0, 1'b0);
    checkOutput("post_rst_ldrb", {32'd0, ld_data}, 64'h000000FF);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 3))
        0: rir = {4'hE, 2'b01, 26'($urandom)};
        1, 2: begin
          rir = $urandom;
          rir[27:25] = 3'b000;
          rir[7] = 1'b1;
          rir[4] = 1'b1;
        end
        default: rir = $urandom;
      endcase
      rea = $urandom;
      if ($urandom_range(0, 2) != 0) rea[2:0] = 3'b000;
      applyStimulus(rir, rea, $urandom, $urandom, pickDelay(), pickDelay(),
                    $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
